stopwatch_counter: RTL and testbench

Timebase and BCD time counter for the stopwatch; sits directly downstream of the run/stop control FSM and consumes its `en` output. Divides the system clock to a centisecond tick and counts elapsed time as six BCD digits (MM:SS.cc) while enabled. It provides a lap-hold freeze of the displayed value and a sticky overflow flag for the display/decoder stage.

---
 rtl/stopwatch_pkg.sv | 19 +
 rtl/bcd_digit.sv | 38 +++
 rtl/stopwatch_counter.sv | 105 ++++++++++
 tb/tb_stopwatch_counter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types for the stopwatch datapath: BCD digit type, digit limits and the
// six-digit MM:SS.cc time record used for live and lap registers.
package stopwatch_pkg;

   typedef logic [3:0] bcd_t;

   localparam bcd_t DIG_MAX9 = 4'd9;
   localparam bcd_t DIG_MAX5 = 4'd5;

   typedef struct packed {
      bcd_t m_t;
      bcd_t m_o;
      bcd_t s_t;
      bcd_t s_o;
      bcd_t cs_t;
      bcd_t cs_o;
   } time_t;

endpackage

// File: rtl/bcd_digit.sv
// One BCD counter digit wrapping at MAX; carry is combinational so a chain of
// digits ripples a full increment within a single edge.
module bcd_digit
   import stopwatch_pkg::*;
#(
   parameter logic [3:0] MAX = DIG_MAX9
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       inc,
   output logic [3:0] q,
   output logic       carry
);

   bcd_t q_q, q_d;

   always_comb begin
      q_d   = q_q;
      carry = inc && (q_q == MAX);
      if (clr) begin
         q_d = '0;
      end else if (inc) begin
         q_d = carry ? 4'd0 : q_q + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/stopwatch_counter.sv
// Centisecond prescaler feeding a six-digit BCD ripple counter (MM:SS.cc), with
// a lap-hold display freeze and a sticky wrap-past-59:59.99 overflow flag.
module stopwatch_counter
   import stopwatch_pkg::*;
#(
   parameter int unsigned CLK_HZ  = 100_000_000,
   parameter int unsigned TICK_HZ = 100
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       clr,
   input  logic       lap,
   output logic [3:0] cs_o,
   output logic [3:0] cs_t,
   output logic [3:0] s_o,
   output logic [3:0] s_t,
   output logic [3:0] m_o,
   output logic [3:0] m_t,
   output logic       tick,
   output logic       hold,
   output logic       ovf
);

   localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
   localparam int unsigned PRE_W = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

   logic [PRE_W-1:0] pre_q, pre_d;
   logic             tick_q, tick_d;
   logic             hold_q, hold_d;
   logic             ovf_q, ovf_d;
   time_t            lap_q, lap_d;
   time_t            live;
   time_t            disp;
   logic             inc_cs;
   logic [5:0]       carry;

   always_comb begin
      inc_cs = en && !clr && (pre_q == PRE_LAST);
      pre_d  = pre_q;
      tick_d = inc_cs;
      ovf_d  = ovf_q | carry[5];
      hold_d = hold_q;
      lap_d  = lap_q;
      if (clr) begin
         pre_d  = '0;
         ovf_d  = 1'b0;
         hold_d = 1'b0;
         lap_d  = '0;
      end else begin
         if (en) begin
            pre_d = inc_cs ? '0 : pre_q + PRE_W'(1);
         end
         // Capture samples the live value before this edge's increment lands.
         if (lap) begin
            if (!hold_q) begin
               lap_d = live;
            end
            hold_d = !hold_q;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pre_q  <= '0;
         tick_q <= 1'b0;
         hold_q <= 1'b0;
         ovf_q  <= 1'b0;
         lap_q  <= '0;
      end else begin
         pre_q  <= pre_d;
         tick_q <= tick_d;
         hold_q <= hold_d;
         ovf_q  <= ovf_d;
         lap_q  <= lap_d;
      end
   end

   bcd_digit #(.MAX(DIG_MAX9)) u_cs_o (.clk(clk), .rst(rst), .clr(clr), .inc(inc_cs),
                                       .q(live.cs_o), .carry(carry[0]));
   bcd_digit #(.MAX(DIG_MAX9)) u_cs_t (.clk(clk), .rst(rst), .clr(clr), .inc(carry[0]),
                                       .q(live.cs_t), .carry(carry[1]));
   bcd_digit #(.MAX(DIG_MAX9)) u_s_o  (.clk(clk), .rst(rst), .clr(clr), .inc(carry[1]),
                                       .q(live.s_o), .carry(carry[2]));
   bcd_digit #(.MAX(DIG_MAX5)) u_s_t  (.clk(clk), .rst(rst), .clr(clr), .inc(carry[2]),
                                       .q(live.s_t), .carry(carry[3]));
   bcd_digit #(.MAX(DIG_MAX9)) u_m_o  (.clk(clk), .rst(rst), .clr(clr), .inc(carry[3]),
                                       .q(live.m_o), .carry(carry[4]));
   bcd_digit #(.MAX(DIG_MAX5)) u_m_t  (.clk(clk), .rst(rst), .clr(clr), .inc(carry[4]),
                                       .q(live.m_t), .carry(carry[5]));

   assign disp = hold_q ? lap_q : live;
   assign cs_o = disp.cs_o;
   assign cs_t = disp.cs_t;
   assign s_o  = disp.s_o;
   assign s_t  = disp.s_t;
   assign m_o  = disp.m_o;
   assign m_t  = disp.m_t;
   assign tick = tick_q;
   assign hold = hold_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Bench for stopwatch_counter at DIV=4: reference model counts elapsed
// centiseconds as a plain integer and derives the expected BCD digits from it.
module tb_stopwatch_counter;

   localparam int DIV  = 4;
   localparam int WRAP = 360000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en  = 1'b0;
   logic clr = 1'b0;
   logic lap = 1'b0;
   logic [3:0] cs_o, cs_t, s_o, s_t, m_o, m_t;
   logic tick, hold, ovf;
   logic [23:0] disp;

   int checks   = 0;
   int failures = 0;

   int live_m, lap_m, pre_m;
   bit hold_m, ovf_m, tick_m;

   stopwatch_counter #(.CLK_HZ(400), .TICK_HZ(100)) dut (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .lap(lap),
      .cs_o(cs_o), .cs_t(cs_t), .s_o(s_o), .s_t(s_t), .m_o(m_o), .m_t(m_t),
      .tick(tick), .hold(hold), .ovf(ovf)
   );

   assign disp = {m_t, m_o, s_t, s_o, cs_t, cs_o};

   always #5 clk = ~clk;

   function automatic logic [23:0] to_bcd(input int c);
      int mm, ss, cc;
      mm = c / 6000;
      ss = (c / 100) % 60;
      cc = c % 100;
      return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), 4'(cc / 10), 4'(cc % 10)};
   endfunction

   task automatic model_reset();
      live_m = 0; lap_m = 0; pre_m = 0;
      hold_m = 0; ovf_m = 0; tick_m = 0;
   endtask

   task automatic model_edge(input logic e, input logic c, input logic l);
      tick_m = 0;
      if (!rst || c) begin
         model_reset();
         return;
      end
      if (l) begin
         if (!hold_m) lap_m = live_m;
         hold_m = !hold_m;
      end
      if (e) begin
         if (pre_m == DIV - 1) begin
            pre_m  = 0;
            live_m = (live_m + 1) % WRAP;
            if (live_m == 0) ovf_m = 1;
            tick_m = 1;
         end else begin
            pre_m++;
         end
      end
   endtask

   task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   task automatic step(input logic e, input logic c, input logic l);
      @(negedge clk);
      en = e; clr = c; lap = l;
      @(posedge clk);
      model_edge(e, c, l);
      #1;
      chk("cyc_digits", disp, hold_m ? to_bcd(lap_m) : to_bcd(live_m));
      chk("cyc_tick", 24'(tick), 24'(tick_m));
      chk("cyc_hold", 24'(hold), 24'(hold_m));
      chk("cyc_ovf", 24'(ovf), 24'(ovf_m));
   endtask

   initial begin
      int n;
      int first;
      model_reset();

      // Power-on reset
      #1 rst = 1'b0;
      #1;
      chk("rst_digits", disp, 24'h0);
      chk("rst_tick", 24'(tick), 24'h0);
      chk("rst_hold", 24'(hold), 24'h0);
      chk("rst_ovf", 24'(ovf), 24'h0);
      #1 rst = 1'b1;

      // Basic count: 400 enabled cycles give 100 ticks
      n = 0;
      for (int i = 0; i < 400; i++) begin
         step(1'b1, 1'b0, 1'b0);
         if (tick) n++;
      end
      chk("basic_ticks", 24'(n), 24'd100);
      chk("basic_value", disp, 24'h000100);

      // Randomized enable / lap / clear traffic
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0);
      end

      // Pause preserves the partial prescaler interval
      step(1'b0, 1'b1, 1'b0);
      repeat (2) step(1'b1, 1'b0, 1'b0);
      repeat (10) step(1'b0, 1'b0, 1'b0);
      first = 0;
      for (int k = 1; k <= 8; k++) begin
         step(1'b1, 1'b0, 1'b0);
         if (tick) begin
            first = k;
            break;
         end
      end
      chk("pause_first_tick", 24'(first), 24'd2);
      chk("pause_value", disp, 24'h000001);

      // Lap hold at 00:01.23, then release at 00:01.73
      step(1'b0, 1'b1, 1'b0);
      repeat (492) step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1);
      repeat (199) step(1'b1, 1'b0, 1'b0);
      chk("lap_frozen", disp, 24'h000123);
      chk("lap_hold_set", 24'(hold), 24'h1);
      step(1'b0, 1'b0, 1'b1);
      chk("lap_release", disp, 24'h000173);
      chk("lap_hold_clr", 24'(hold), 24'h0);

      // Asynchronous reset mid-count at 00:03.47
      step(1'b0, 1'b1, 1'b0);
      repeat (347 * 4 + 2) step(1'b1, 1'b0, 1'b0);
      chk("pre_rst_value", disp, 24'h000347);
      @(negedge clk);
      en = 1'b1;
      #1 rst = 1'b0;
      model_reset();
      #1;
      chk("arst_digits", disp, 24'h0);
      chk("arst_tick", 24'(tick), 24'h0);
      chk("arst_hold", 24'(hold), 24'h0);
      chk("arst_ovf", 24'(ovf), 24'h0);
      repeat (2) step(1'b1, 1'b0, 1'b0);
      rst = 1'b1;
      first = 0;
      for (int k = 1; k <= 8; k++) begin
         step(1'b1, 1'b0, 1'b0);
         if (tick) begin
            first = k;
            break;
         end
      end
      chk("rst_release_first_tick", 24'(first), 24'd4);

      // Clear beats enable on an edge where the prescaler is at its last value
      step(1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b1);
      repeat (2) step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      chk("clr_digits", disp, 24'h0);
      chk("clr_tick", 24'(tick), 24'h0);
      chk("clr_hold", 24'(hold), 24'h0);
      first = 0;
      for (int k = 1; k <= 8; k++) begin
         step(1'b1, 1'b0, 1'b0);
         if (tick) begin
            first = k;
            break;
         end
      end
      chk("clr_pre_zero", 24'(first), 24'd4);

      // Full wrap: preload 59:59.96 then count through 59:59.99
      step(1'b0, 1'b1, 1'b0);
      force dut.u_m_t.q_q  = 4'd5;
      force dut.u_m_o.q_q  = 4'd9;
      force dut.u_s_t.q_q  = 4'd5;
      force dut.u_s_o.q_q  = 4'd9;
      force dut.u_cs_t.q_q = 4'd9;
      force dut.u_cs_o.q_q = 4'd6;
      live_m = 359996;
      step(1'b0, 1'b0, 1'b0);
      release dut.u_m_t.q_q;
      release dut.u_m_o.q_q;
      release dut.u_s_t.q_q;
      release dut.u_s_o.q_q;
      release dut.u_cs_t.q_q;
      release dut.u_cs_o.q_q;
      repeat (12) step(1'b1, 1'b0, 1'b0);
      chk("wrap_max", disp, 24'h595999);
      chk("wrap_no_ovf_yet", 24'(ovf), 24'h0);
      repeat (4) step(1'b1, 1'b0, 1'b0);
      chk("wrap_zero", disp, 24'h0);
      chk("wrap_ovf", 24'(ovf), 24'h1);
      chk("wrap_tick", 24'(tick), 24'h1);
      repeat (20) step(1'b1, 1'b0, 1'b0);
      chk("ovf_sticky", 24'(ovf), 24'h1);
      step(1'b1, 1'b1, 1'b0);
      chk("ovf_cleared", 24'(ovf), 24'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
